// File: rtl/mux_scan_serializer_pkg.sv
// rtl/mux_scan_serializer_pkg.sv - shared types and select helpers for the mux scan serializer
package mux_scan_serializer_pkg;

  localparam int SEL_W  = 3;
  localparam int DATA_W = 8;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  function automatic logic [SEL_W-1:0] first_sel(input logic msb_first);
    return msb_first ? 3'd7 : 3'd0;
  endfunction

  function automatic logic [SEL_W-1:0] last_sel(input logic msb_first);
    return msb_first ? 3'd0 : 3'd7;
  endfunction

endpackage

// File: rtl/mux.sv
// rtl/mux.sv - 8-to-1 bit multiplexer driven by the scan serializer
module mux (
  input  logic [2:0] s,
  input  logic [7:0] i,
  output logic       y
);

  assign y = i[s];

endmodule

// File: rtl/mux_scan_serializer.sv
// rtl/mux_scan_serializer.sv - captures a byte and walks the mux select across it,
// holding each bit for DIV clocks and flagging the last cycle of each word
module mux_scan_serializer
  import mux_scan_serializer_pkg::*;
#(
  parameter int DIV       = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] din,
  input  logic              clr,
  output logic              sout,
  output logic              sout_valid,
  output logic              busy,
  output logic              done
);

  localparam logic [7:0]       DIV_M1 = 8'(DIV - 1);
  localparam logic [SEL_W-1:0] FIRST  = first_sel(MSB_FIRST);
  localparam logic [SEL_W-1:0] LAST   = last_sel(MSB_FIRST);

  state_e            state_q, state_n;
  logic [DATA_W-1:0] word_q, word_n;
  logic [SEL_W-1:0]  sel_q, sel_n;
  logic [7:0]        div_q, div_n;
  logic              last_cyc;
  logic              done_n;
  logic              mux_y;

  assign last_cyc = (state_q == SHIFT) && (sel_q == LAST) && (div_q == DIV_M1);

  // clr outranks capture; load_ready already covers both IDLE and the last word cycle
  always_comb begin
    state_n = state_q;
    word_n  = word_q;
    sel_n   = sel_q;
    div_n   = div_q;
    if (clr) begin
      state_n = IDLE;
      sel_n   = FIRST;
      div_n   = 8'd0;
    end else if (load_valid && load_ready) begin
      state_n = SHIFT;
      word_n  = din;
      sel_n   = FIRST;
      div_n   = 8'd0;
    end else if (state_q == SHIFT) begin
      if (last_cyc) begin
        state_n = IDLE;
        sel_n   = FIRST;
        div_n   = 8'd0;
      end else if (div_q == DIV_M1) begin
        div_n = 8'd0;
        sel_n = MSB_FIRST ? sel_q - 1'b1 : sel_q + 1'b1;
      end else begin
        div_n = div_q + 8'd1;
      end
    end
  end

  assign done_n = (state_n == SHIFT) && (sel_n == LAST) && (div_n == DIV_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      word_q     <= '0;
      sel_q      <= '0;
      div_q      <= 8'd0;
      load_ready <= 1'b1;
      sout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_n;
      word_q     <= word_n;
      sel_q      <= sel_n;
      div_q      <= div_n;
      load_ready <= (state_n == IDLE) || done_n;
      sout_valid <= (state_n == SHIFT);
      busy       <= (state_n == SHIFT);
      done       <= done_n;
    end
  end

  mux u_mux (
    .s (sel_q),
    .i (word_q),
    .y (mux_y)
  );

  assign sout = (state_q == SHIFT) && mux_y;

endmodule
